// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the remote command link.
// Used by the byte receiver and by the command assembler.
package remote_comm_pkg;

    typedef enum logic {HIGH = 1'b0, LOW = 1'b1} asm_state_t;
    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} rx_state_t;

    localparam int UART_BITS        = 10;
    localparam int DEFAULT_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: synchronizes RX, samples mid-bit, and emits a one-cycle
// byte_rdy or frm_err once the stop bit has been sampled.
module uart_byte_rx
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_rdy,
    output logic [7:0] byte_data,
    output logic       frm_err
);
    localparam int                CNT_W    = $clog2(BAUD_DIV + 1);
    localparam int                BIT_W    = $clog2(UART_BITS);
    localparam logic [CNT_W-1:0]  HALF_BIT = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0]  FULL_BIT = CNT_W'(BAUD_DIV);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(UART_BITS - 1);

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    rx_state_t        state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [7:0]       shift_q;
    logic             byte_rdy_q;
    logic             frm_err_q;
    logic [7:0]       byte_data_q;
    logic             fall_edge;

    assign fall_edge = rx_prev_q & ~rx_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_rdy_q  <= 1'b0;
            frm_err_q   <= 1'b0;
            byte_data_q <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            byte_rdy_q <= 1'b0;
            frm_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fall_edge) begin
                        state_q    <= RECV;
                        baud_cnt_q <= HALF_BIT;
                        bit_cnt_q  <= '0;
                    end
                end
                RECV: begin
                    // Counter value 1 marks the sampling cycle for the current bit.
                    if (baud_cnt_q == CNT_W'(1)) begin
                        baud_cnt_q <= FULL_BIT;
                        bit_cnt_q  <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == '0) begin
                            if (rx_sync_q) begin
                                state_q <= IDLE;
                            end
                        end else if (bit_cnt_q == LAST_BIT) begin
                            byte_rdy_q  <= rx_sync_q;
                            frm_err_q   <= ~rx_sync_q;
                            byte_data_q <= shift_q;
                            state_q     <= IDLE;
                        end else begin
                            shift_q <= {rx_sync_q, shift_q[7:1]};
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_rdy  = byte_rdy_q;
    assign byte_data = byte_data_q;
    assign frm_err   = frm_err_q;

endmodule

// File: rtl/remote_cmd_rx.sv
// Assembles two received bytes (high first) into a 16-bit command with a sticky
// ready flag. Define CMD_RX_TIMEOUT_EN to drop a stale high byte after TIMEOUT_CYC.
module remote_cmd_rx
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV    = DEFAULT_BAUD_DIV,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        frm_err
);
    logic       byte_rdy;
    logic [7:0] byte_data;
    asm_state_t asm_state_q;
    logic [7:0] hi_byte_q;
    logic [15:0] cmd_q;
    logic       cmd_rdy_q;
    logic       tmo_hit;

    uart_byte_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (RX),
        .byte_rdy  (byte_rdy),
        .byte_data (byte_data),
        .frm_err   (frm_err)
    );

`ifdef CMD_RX_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMO_W-1:0] tmo_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (asm_state_q == LOW) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign tmo_hit = (asm_state_q == LOW) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`else
    // TIMEOUT_CYC only matters when the timeout counter is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_state_q <= HIGH;
            hi_byte_q   <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
        end else begin
            case (asm_state_q)
                HIGH: begin
                    if (byte_rdy) begin
                        hi_byte_q   <= byte_data;
                        asm_state_q <= LOW;
                    end
                end
                LOW: begin
                    // A byte arriving in the same cycle as the timeout still completes.
                    if (byte_rdy) begin
                        cmd_q       <= {hi_byte_q, byte_data};
                        asm_state_q <= HIGH;
                    end else if (frm_err || tmo_hit) begin
                        hi_byte_q   <= '0;
                        asm_state_q <= HIGH;
                    end
                end
                default: asm_state_q <= HIGH;
            endcase

            if (byte_rdy && asm_state_q == LOW) begin
                cmd_rdy_q <= 1'b1;
            end else if (clr_cmd_rdy || (byte_rdy && asm_state_q == HIGH)) begin
                cmd_rdy_q <= 1'b0;
            end
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_remote_cmd_rx.sv
// Directed bench for remote_cmd_rx at BAUD_DIV=16, TIMEOUT_CYC=500.
module tb_remote_cmd_rx;
    import remote_comm_pkg::*;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        clr_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;

    int checks   = 0;
    int errors   = 0;
    int byte_cnt = 0;
    int frm_cnt  = 0;

    remote_cmd_rx #(
        .BAUD_DIV    (BD),
        .TIMEOUT_CYC (500)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .frm_err     (frm_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dut.byte_rdy === 1'b1) byte_cnt++;
        if (frm_err === 1'b1) frm_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RX = frame[i];
            repeat (BD - 1) @(negedge clk);
        end
        @(negedge clk);
        RX = 1'b1;
        repeat (BD) @(negedge clk);
        $display("sent byte %02h stop %0b", b, stop);
    endtask

    task automatic wait_byte_rdy(input string tag);
        int n;
        n = 0;
        while (dut.byte_rdy !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check_eq({tag, "_byte_rdy_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int f0;
        rst = 1'b1;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_cmd", 32'(cmd), 32'h0);
        check_eq("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        check_eq("rst_frm_err", 32'(frm_err), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic command 0xA53C with exact ready latency.
        send_byte(8'hA5, 1'b1);
        fork
            send_byte(8'h3C, 1'b1);
            begin
                wait_byte_rdy("t1");
                check_eq("t1_rdy_at_byte", 32'(cmd_rdy), 32'h0);
                @(negedge clk);
                check_eq("t1_rdy_next", 32'(cmd_rdy), 32'h1);
                check_eq("t1_cmd", 32'(cmd), 32'hA53C);
            end
        join
        check_eq("t1_no_frm", 32'(frm_cnt), 32'h0);

        // Clear, then set and clear colliding.
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check_eq("t2_clr", 32'(cmd_rdy), 32'h0);
        check_eq("t2_cmd_hold", 32'(cmd), 32'hA53C);
        send_byte(8'h12, 1'b1);
        fork
            send_byte(8'h34, 1'b1);
            begin
                wait_byte_rdy("t2");
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                check_eq("t2_set_wins", 32'(cmd_rdy), 32'h1);
                check_eq("t2_cmd", 32'(cmd), 32'h1234);
            end
        join

        // Framing error discards a held high byte.
        send_byte(8'h56, 1'b1);
        check_eq("t3_hi_clears_rdy", 32'(cmd_rdy), 32'h0);
        send_byte(8'hFF, 1'b0);
        check_eq("t3_frm_pulse", 32'(frm_cnt), 32'h1);
        send_byte(8'h12, 1'b1);
        check_eq("t3_cmd_hold", 32'(cmd), 32'h1234);
        check_eq("t3_rdy_low", 32'(cmd_rdy), 32'h0);
        send_byte(8'h34, 1'b1);
        check_eq("t3_cmd", 32'(cmd), 32'h1234);
        check_eq("t3_rdy", 32'(cmd_rdy), 32'h1);

        // Short low glitch on idle line.
        b0 = byte_cnt;
        f0 = frm_cnt;
        @(negedge clk);
        RX = 1'b0;
        repeat (BD / 4) @(negedge clk);
        RX = 1'b1;
        repeat (3 * BD) @(negedge clk);
        check_eq("t4_no_byte", 32'(byte_cnt), 32'(b0));
        check_eq("t4_no_frm", 32'(frm_cnt), 32'(f0));
        check_eq("t4_state_high", 32'(dut.asm_state_q), 32'(HIGH));
        check_eq("t4_rdy_kept", 32'(cmd_rdy), 32'h1);

        // Reset in the middle of the second byte of 0xBEEF.
        send_byte(8'hBE, 1'b1);
        fork
            send_byte(8'hEF, 1'b1);
            begin
                repeat (BD * 5) @(negedge clk);
                rst = 1'b1;
            end
        join
        check_eq("t5_rst_cmd", 32'(cmd), 32'h0);
        check_eq("t5_rst_rdy", 32'(cmd_rdy), 32'h0);
        rst = 1'b0;
        repeat (BD) @(negedge clk);
        send_byte(8'hCA, 1'b1);
        send_byte(8'hFE, 1'b1);
        check_eq("t5_cmd", 32'(cmd), 32'hCAFE);
        check_eq("t5_rdy", 32'(cmd_rdy), 32'h1);

        // Long gap between bytes.
        send_byte(8'h11, 1'b1);
        repeat (600) @(negedge clk);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
`ifdef CMD_RX_TIMEOUT_EN
        check_eq("t6_cmd", 32'(cmd), 32'h2233);
        check_eq("t6_rdy", 32'(cmd_rdy), 32'h1);
`else
        check_eq("t6_cmd", 32'(cmd), 32'h1122);
        check_eq("t6_rdy", 32'(cmd_rdy), 32'h0);
`endif
        check_eq("t6_no_frm", 32'(frm_cnt), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
